// File: rtl/arbitro_mux4a1_pkg.sv
// Shared definitions for the round-robin arbiter around the 4-to-1 multiplexer.
package arbitro_mux4a1_pkg;

    localparam int          N_REQ     = 4;
    localparam logic [2:0]  SEL_IDLE  = 3'b100;
    localparam int          ANCHO_DEF = 3;

    // Burst counter width; never narrower than one bit.
    function automatic int cnt_w(input int max_rafaga);
        int w;
        w = $clog2(max_rafaga);
        return (w < 1) ? 1 : w;
    endfunction

    // Requester index 'off' positions after 'base', modulo 4.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [2:0] off);
        logic [2:0] s;
        s = {1'b0, base} + off;
        return s[1:0];
    endfunction

    // One-hot vector for a requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_mux4a1_mux.sv
// Shared 4-to-1 data multiplexer; any select with bit 2 set yields zero.
module arbitro_mux4a1_mux
    import arbitro_mux4a1_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic [2:0]       sel_i,
    input  logic [ANCHO-1:0] a_i,
    input  logic [ANCHO-1:0] b_i,
    input  logic [ANCHO-1:0] c_i,
    input  logic [ANCHO-1:0] d_i,
    output logic [ANCHO-1:0] y_o
);

    // Pure combinational steering of the selected input.
    always_comb begin
        y_o = '0;
        case (sel_i)
            3'd0:    y_o = a_i;
            3'd1:    y_o = b_i;
            3'd2:    y_o = c_i;
            3'd3:    y_o = d_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_mux4a1.sv
// Round-robin arbiter sharing one 4-to-1 mux among requesters A..D, with
// burst limiting, registered data output and a one-hot consumption grant.
module arbitro_mux4a1
    import arbitro_mux4a1_pkg::*;
#(
    parameter int ANCHO      = ANCHO_DEF,
    parameter int MAX_RAFAGA = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       Req,
    input  logic [ANCHO-1:0] A,
    input  logic [ANCHO-1:0] B,
    input  logic [ANCHO-1:0] C,
    input  logic [ANCHO-1:0] D,
    output logic [3:0]       Grant,
    output logic [2:0]       Selector,
    output logic [ANCHO-1:0] Salida,
    output logic             Valido
);

    localparam int               CNT_W    = cnt_w(MAX_RAFAGA);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_RAFAGA - 1);

    logic [3:0]       grant_q,    grant_d;
    logic [2:0]       selector_q, selector_d;
    logic [ANCHO-1:0] salida_q,   salida_d;
    logic             valido_q,   valido_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       ultimo_q,   ultimo_d;

    logic [1:0]       g_cur;
    logic [3:0]       otros;
    logic             keep;
    logic             found;
    logic [1:0]       scan_g;
    logic [1:0]       scan_idx;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic [2:0]       mux_sel;
    logic [ANCHO-1:0] mux_y;

    assign g_cur = selector_q[1:0];

    // Next-grant decision: keep the current owner while its burst allows,
    // otherwise scan round-robin starting just after the last winner.
    always_comb begin
        otros    = Req & ~onehot4(g_cur);
        keep     = valido_q && Req[g_cur] && ((cnt_q < CNT_LAST) || (otros == 4'b0000));
        found    = 1'b0;
        scan_g   = ultimo_q;
        scan_idx = ultimo_q;
        for (int off = 1; off <= N_REQ; off++) begin
            scan_idx = rr_idx(ultimo_q, 3'(off));
            if (!found && Req[scan_idx]) begin
                found  = 1'b1;
                scan_g = scan_idx;
            end
        end
        gnt_vld = keep || found;
        gnt_idx = keep ? g_cur : scan_g;
        mux_sel = gnt_vld ? {1'b0, gnt_idx} : SEL_IDLE;
    end

    arbitro_mux4a1_mux #(
        .ANCHO (ANCHO)
    ) u_mux (
        .sel_i (mux_sel),
        .a_i   (A),
        .b_i   (B),
        .c_i   (C),
        .d_i   (D),
        .y_o   (mux_y)
    );

    // Next state of the output registers, burst counter and last winner.
    always_comb begin
        grant_d    = grant_q;
        selector_d = selector_q;
        salida_d   = salida_q;
        valido_d   = valido_q;
        cnt_d      = cnt_q;
        ultimo_d   = ultimo_q;
        if (gnt_vld) begin
            grant_d    = onehot4(gnt_idx);
            selector_d = {1'b0, gnt_idx};
            salida_d   = mux_y;
            valido_d   = 1'b1;
            ultimo_d   = gnt_idx;
            if (valido_q && (gnt_idx == g_cur)) begin
                // A lone requester at the burst limit keeps the grant; cnt wraps.
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
            end
        end else begin
            grant_d    = 4'b0000;
            selector_d = SEL_IDLE;
            valido_d   = 1'b0;
            cnt_d      = '0;
        end
    end

    // State registers; reset clears outputs at once and gives A first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= 4'b0000;
            selector_q <= SEL_IDLE;
            salida_q   <= '0;
            valido_q   <= 1'b0;
            cnt_q      <= '0;
            ultimo_q   <= 2'd3;
        end else begin
            grant_q    <= grant_d;
            selector_q <= selector_d;
            salida_q   <= salida_d;
            valido_q   <= valido_d;
            cnt_q      <= cnt_d;
            ultimo_q   <= ultimo_d;
        end
    end

    assign Grant    = grant_q;
    assign Selector = selector_q;
    assign Salida   = salida_q;
    assign Valido   = valido_q;

endmodule
